placar_basquete_param: RTL
==========================

PLACAR_BASQUETE_PARAM -- requirements
Module: placar_basquete_param

Interface
REQ-001 SHALL have parameter N_TIMES, default 2, number of team score channels (2..8).
REQ-002 SHALL have parameter PONTOS_W, default 8, width of each team score.
REQ-003 SHALL have parameter MAX_PONTOS, default 199, highest legal score (at most 2^PONTOS_W-1).
REQ-004 SHALL have parameter T_LONGO, default 24, long shot-clock preset in ticks.
REQ-005 SHALL have parameter T_CURTO, default 14, short shot-clock preset in ticks (less than or equal to T_LONGO).
REQ-006 SHALL have parameter BUZ_TICKS, default 3, buzzer hold time in ticks.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port clr_n, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port tick, input, 1 bit, one-cycle 1 Hz strobe.
REQ-010 SHALL have port evento, input, 1 bit, one-cycle strobe to apply a score change.
REQ-011 SHALL have port sel_time, input, $clog2(N_TIMES) bits, target team.
REQ-012 SHALL have port pontos, input, 2 bits, magnitude 0..3.
REQ-013 SHALL have port negativo, input, 1 bit; 1 subtracts, 0 adds.
REQ-014 SHALL have port recarga, input, 1 bit, one-cycle strobe to reload the shot clock.
REQ-015 SHALL have port curto, input, 1 bit, preset select on reload (1 = T_CURTO, 0 = T_LONGO).
REQ-016 SHALL have port parar, input, 1 bit, level; 1 freezes the shot clock.
REQ-017 SHALL have port placar, output, N_TIMES*PONTOS_W bits, team scores with team 0 in the LSBs.
REQ-018 SHALL have port cronometro, output, $clog2(T_LONGO+1) bits, remaining shot-clock ticks.
REQ-019 SHALL have port buzzer, output, 1 bit, shot-clock expiry alarm.
REQ-020 SHALL have port led_erro, output, 1 bit, last score request rejected.

Function
REQ-021 SHALL process a score request only in a cycle where evento=1; placar SHALL update on the next edge (1-cycle latency).
REQ-022 SHALL treat pontos=0 as a no-op that leaves led_erro unchanged.
REQ-023 SHALL reject a request, leaving the score unchanged and setting led_erro=1, on: add with result > MAX_PONTOS; subtract with result < 0; sel_time >= N_TIMES.
REQ-024 SHALL, on an accepted request, clear led_erro; led_erro SHALL otherwise hold its value.
REQ-025 SHALL implement a shot-clock FSM with states PARADO, CONTANDO and ESGOTADO.
REQ-026 SHALL move PARADO->CONTANDO when parar=0, and CONTANDO->PARADO when parar=1.
REQ-027 SHALL, in CONTANDO on tick, decrement cronometro by 1; on the tick where cronometro reaches 0 it SHALL enter ESGOTADO.
REQ-028 SHALL, in ESGOTADO, hold cronometro=0 and assert buzzer for exactly BUZ_TICKS ticks, then deassert buzzer and remain in ESGOTADO until a reload.
REQ-029 SHALL, on recarga, load cronometro with T_CURTO if curto=1, else T_LONGO; buzzer SHALL clear and the FSM SHALL go to PARADO if parar=1, else CONTANDO.
REQ-030 SHALL treat an accepted positive score request as an implicit reload to T_LONGO.
REQ-031 SHALL give recarga or an implicit reload priority over a coincident tick; no decrement occurs in that cycle.
REQ-032 SHALL make every team channel independent; one request affects only placar[sel_time].

Reset
REQ-033 SHALL, with clr_n=0, immediately set placar=0, cronometro=T_LONGO, FSM=PARADO, buzzer=0, led_erro=0 and clear the undo register, independent of clk.
REQ-034 SHALL, when reset is asserted mid-count or mid-buzzer, abandon that operation with no residual buzzer time; the first tick after release follows REQ-026.

Configuration
REQ-035 SHALL compile a one-deep undo feature when macro PLACAR_UNDO_EN is defined: extra input port desfazer (1 bit, strobe) restores the team and score changed by the last accepted request and then empties the register; desfazer with an empty register sets led_erro=1.
REQ-036 SHALL, without PLACAR_UNDO_EN, have no desfazer port and no undo storage; all other behaviour SHALL be identical.

Verification
REQ-037 Reset, then evento with sel_time=1, pontos=3, negativo=0 -> placar[1]=3 one cycle later, cronometro=24, led_erro=0.
REQ-038 Team 0 at 198, then +2 request -> placar[0] stays 198, led_erro=1; then +1 request -> placar[0]=199, led_erro=0.
REQ-039 Team 0 at 1, then -2 request -> score stays 1, led_erro=1.
REQ-040 parar=0 and 24 ticks -> cronometro=0, buzzer high for exactly 3 ticks then low; recarga with curto=1 -> cronometro=14.
REQ-041 recarga and tick in the same cycle with curto=0 -> cronometro=24, no decrement; clr_n pulse mid-buzzer -> buzzer=0 immediately.
REQ-042 With PLACAR_UNDO_EN: +2 to team 1 then desfazer -> placar[1] returns to its prior value; a second desfazer -> led_erro=1.

Source files
------------

// File: rtl/placar_basquete_param.sv
// Basketball scoreboard: per-team score channels, shot clock with buzzer, error LED.
// Define PLACAR_UNDO_EN to add the one-deep undo port (desfazer).
module placar_canal #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n)  q <= '0;
    else if (ld) q <= d;
endmodule

module placar_basquete_param #(
  parameter int N_TIMES    = 2,
  parameter int PONTOS_W   = 8,
  parameter int MAX_PONTOS = 199,
  parameter int T_LONGO    = 24,
  parameter int T_CURTO    = 14,
  parameter int BUZ_TICKS  = 3
) (
  input  logic                          clk,
  input  logic                          clr_n,
  input  logic                          tick,
  input  logic                          evento,
  input  logic [$clog2(N_TIMES)-1:0]    sel_time,
  input  logic [1:0]                    pontos,
  input  logic                          negativo,
  input  logic                          recarga,
  input  logic                          curto,
  input  logic                          parar,
`ifdef PLACAR_UNDO_EN
  input  logic                          desfazer,
`endif
  output logic [N_TIMES*PONTOS_W-1:0]   placar,
  output logic [$clog2(T_LONGO+1)-1:0]  cronometro,
  output logic                          buzzer,
  output logic                          led_erro
);
  localparam int SEL_W = $clog2(N_TIMES);
  localparam int CR_W  = $clog2(T_LONGO+1);
  localparam int BZ_W  = $clog2(BUZ_TICKS+1);
  localparam int S_W   = PONTOS_W + 2;

  typedef enum logic [1:0] {PARADO, CONTANDO, ESGOTADO} est_t;

  logic [N_TIMES-1:0][PONTOS_W-1:0] pts;
  logic [N_TIMES-1:0]               ld;
  logic [PONTOS_W-1:0]              cur, novo, d_val;
  logic [S_W-1:0]                   soma;
  logic                             sel_ok, req, aceita, rejeita, do_ld;
  logic [SEL_W-1:0]                 ld_sel;
  logic                             desf_ok, desf_err;
  logic [SEL_W-1:0]                 undo_sel;
  logic [PONTOS_W-1:0]              undo_val;

  always_comb begin
    cur    = '0;
    sel_ok = 1'b0;
    for (int i = 0; i < N_TIMES; i++)
      if (sel_time == SEL_W'(i)) begin
        cur    = pts[i];
        sel_ok = 1'b1;
      end
  end

  assign soma    = S_W'(cur) + S_W'(pontos);
  assign req     = evento && (pontos != 2'd0);
  assign aceita  = req && sel_ok &&
                   (negativo ? (S_W'(cur) >= S_W'(pontos)) : (soma <= S_W'(MAX_PONTOS)));
  assign rejeita = req && !aceita;
  assign novo    = negativo ? PONTOS_W'(S_W'(cur) - S_W'(pontos)) : soma[PONTOS_W-1:0];

`ifdef PLACAR_UNDO_EN
  // A score request in the same cycle wins; the undo strobe is then ignored.
  logic undo_vld;
  assign desf_ok  = desfazer && !req && undo_vld;
  assign desf_err = desfazer && !req && !undo_vld;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      undo_vld <= 1'b0;
      undo_sel <= '0;
      undo_val <= '0;
    end else if (aceita) begin
      undo_vld <= 1'b1;
      undo_sel <= sel_time;
      undo_val <= cur;
    end else if (desf_ok) begin
      undo_vld <= 1'b0;
    end
`else
  assign desf_ok  = 1'b0;
  assign desf_err = 1'b0;
  assign undo_sel = '0;
  assign undo_val = '0;
`endif

  assign do_ld  = aceita || desf_ok;
  assign ld_sel = desf_ok ? undo_sel : sel_time;
  assign d_val  = desf_ok ? undo_val : novo;

  always_comb
    for (int i = 0; i < N_TIMES; i++)
      ld[i] = do_ld && (ld_sel == SEL_W'(i));

  placar_canal #(.W(PONTOS_W)) u_canal [N_TIMES-1:0] (
    .clk   (clk),
    .clr_n (clr_n),
    .ld    (ld),
    .d     ({N_TIMES{d_val}}),
    .q     (pts)
  );

  assign placar = pts;

  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n)                   led_erro <= 1'b0;
    else if (rejeita || desf_err) led_erro <= 1'b1;
    else if (do_ld)               led_erro <= 1'b0;

  // Shot clock: any reload (explicit or from an accepted basket) beats a tick.
  est_t             est, est_n;
  logic [CR_W-1:0]  cron_n;
  logic [BZ_W-1:0]  buz_cnt, buz_n;
  logic             recarga_ef;

  assign recarga_ef = recarga || (aceita && !negativo);

  always_comb begin
    est_n  = est;
    cron_n = cronometro;
    buz_n  = buz_cnt;
    if (recarga_ef) begin
      cron_n = (recarga && curto) ? CR_W'(T_CURTO) : CR_W'(T_LONGO);
      buz_n  = '0;
      est_n  = parar ? PARADO : CONTANDO;
    end else begin
      case (est)
        PARADO:   if (!parar) est_n = CONTANDO;
        CONTANDO:
          if (parar) est_n = PARADO;
          else if (tick) begin
            if (cronometro <= CR_W'(1)) begin
              cron_n = '0;
              buz_n  = BZ_W'(BUZ_TICKS);
              est_n  = ESGOTADO;
            end else begin
              cron_n = cronometro - CR_W'(1);
            end
          end
        ESGOTADO: if (tick && buz_cnt != '0) buz_n = buz_cnt - BZ_W'(1);
        default:  est_n = PARADO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      est        <= PARADO;
      cronometro <= CR_W'(T_LONGO);
      buz_cnt    <= '0;
    end else begin
      est        <= est_n;
      cronometro <= cron_n;
      buz_cnt    <= buz_n;
    end

  assign buzzer = (buz_cnt != '0);
endmodule
